// File: rtl/fb_pkg.sv
// Shared constants and FSM state type for the frame-buffer scan master.
package fb_pkg;

    localparam int unsigned FB_ADDR_W     = 10;
    localparam int unsigned FB_DATA_W     = 32;
    localparam int unsigned FB_RD_LATENCY = 1;

    typedef enum logic [1:0] {
        StIdle,
        StIssue,
        StDrain,
        StFin
    } fb_state_e;

endpackage

// File: rtl/fb_scan_fifo.sv
// Output buffer for the scan master: data word plus last flag, with occupancy count.
module fb_scan_fifo #(
    parameter int unsigned Width = 33,
    parameter int unsigned Depth = 4
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     push_i,
    input  logic [Width-1:0]         wdata_i,
    input  logic                     pop_i,
    output logic [Width-1:0]         rdata_o,
    output logic [$clog2(Depth):0]   count_o,
    output logic                     empty_o,
    output logic                     full_o
);

    localparam int unsigned PtrW = $clog2(Depth);
    localparam int unsigned CntW = PtrW + 1;

    logic [Width-1:0] mem_q [Depth];
    logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
    logic [CntW-1:0]  count_q, count_d;
    logic             do_push, do_pop;

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == CntW'(Depth));
    assign count_o = count_q;
    assign rdata_o = mem_q[rd_ptr_q];

    assign do_pop  = pop_i && !empty_o;
    // A push into a full FIFO is only legal when the head leaves in the same cycle.
    assign do_push = push_i && (!full_o || do_pop);

    always_comb begin
        count_d = count_q;
        if (do_push && !do_pop) begin
            count_d = count_q + CntW'(1);
        end else if (do_pop && !do_push) begin
            count_d = count_q - CntW'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < Depth; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                mem_q[wr_ptr_q] <= wdata_i;
                wr_ptr_q        <= wr_ptr_q + PtrW'(1);
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + PtrW'(1);
            end
            count_q <= count_d;
        end
    end

    overflow_a: assert property (@(posedge clk) disable iff (!reset_n)
        !(push_i && full_o && !pop_i));

endmodule

// File: rtl/fb_scan_master.sv
// Avalon-MM read initiator sweeping a word range of frame memory into a valid/ready stream.
module fb_scan_master
    import fb_pkg::*;
#(
    parameter int unsigned ADDR_W     = FB_ADDR_W,
    parameter int unsigned DATA_W     = FB_DATA_W,
    parameter int unsigned LEN_W      = FB_ADDR_W + 1,
    parameter int unsigned RD_LATENCY = FB_RD_LATENCY,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                start,
    input  logic [ADDR_W-1:0]   base_addr,
    input  logic [LEN_W-1:0]    length,
    output logic                busy,
    output logic                done,
    output logic [ADDR_W-1:0]   avm_address,
    output logic                avm_chipselect,
    output logic                avm_write,
    output logic [DATA_W/8-1:0] avm_byteenable,
    output logic                avm_clken,
    input  logic [DATA_W-1:0]   avm_readdata,
    output logic [DATA_W-1:0]   st_data,
    output logic                st_valid,
    input  logic                st_ready,
    output logic                st_last
);

    localparam int unsigned CntW = $clog2(FIFO_DEPTH) + 1;

    fb_state_e             state_q, state_d;
    logic [ADDR_W-1:0]     addr_q, addr_d;
    logic [LEN_W-1:0]      remain_q, remain_d;
    logic [RD_LATENCY-1:0] tag_q, tag_d, tag_last_q, tag_last_d;
    logic [CntW-1:0]       fifo_count, inflight;
    logic [CntW:0]         occupancy;
    logic [DATA_W:0]       fifo_rdata;
    logic                  fifo_empty, fifo_full, issue, pop;

    always_comb begin
        inflight = '0;
        for (int i = 0; i < RD_LATENCY; i++) begin
            inflight = inflight + CntW'(tag_q[i]);
        end
    end

    // Reads reserve a FIFO slot at issue time, so the buffer can never overflow.
    assign occupancy = {1'b0, fifo_count} + {1'b0, inflight};
    assign issue     = (state_q == StIssue) && (remain_q != '0) && !fifo_full &&
                       (occupancy < (CntW + 1)'(FIFO_DEPTH));

    always_comb begin
        tag_d[0]      = issue;
        tag_last_d[0] = issue && (remain_q == LEN_W'(1));
        for (int i = 1; i < RD_LATENCY; i++) begin
            tag_d[i]      = tag_q[i-1];
            tag_last_d[i] = tag_last_q[i-1];
        end
    end

    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        remain_d = remain_q;
        case (state_q)
            StIdle: begin
                if (start) begin
                    if (length != '0) begin
                        addr_d   = base_addr;
                        remain_d = length;
                        state_d  = StIssue;
                    end else begin
                        state_d = StFin;
                    end
                end
            end
            StIssue: begin
                if (issue) begin
                    addr_d   = addr_q + ADDR_W'(1);
                    remain_d = remain_q - LEN_W'(1);
                    if (remain_q == LEN_W'(1)) begin
                        state_d = StDrain;
                    end
                end
            end
            StDrain: begin
                if (pop && st_last) begin
                    state_d = StFin;
                end
            end
            StFin:   state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= StIdle;
            addr_q     <= '0;
            remain_q   <= '0;
            tag_q      <= '0;
            tag_last_q <= '0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            remain_q   <= remain_d;
            tag_q      <= tag_d;
            tag_last_q <= tag_last_d;
        end
    end

    fb_scan_fifo #(
        .Width (DATA_W + 1),
        .Depth (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .push_i  (tag_q[RD_LATENCY-1]),
        .wdata_i ({tag_last_q[RD_LATENCY-1], avm_readdata}),
        .pop_i   (pop),
        .rdata_o (fifo_rdata),
        .count_o (fifo_count),
        .empty_o (fifo_empty),
        .full_o  (fifo_full)
    );

    assign st_valid = !fifo_empty;
    assign st_data  = fifo_rdata[DATA_W-1:0];
    // Stale last flags remain in freed slots; only the live head may assert it.
    assign st_last  = fifo_rdata[DATA_W] && !fifo_empty;
    assign pop      = st_valid && st_ready;

    assign busy           = (state_q == StIssue) || (state_q == StDrain);
    assign done           = (state_q == StFin);
    assign avm_address    = addr_q;
    assign avm_chipselect = issue;
    assign avm_write      = 1'b0;
    assign avm_byteenable = '1;
    assign avm_clken      = 1'b1;

endmodule

// File: tb/tb_fb_scan_master.sv
// Self-checking bench for fb_scan_master: vector table of transfers plus scoreboarded stream.
module tb_fb_scan_master;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        start;
    logic [9:0]  base_addr;
    logic [10:0] length;
    logic        busy, done;
    logic [9:0]  avm_address;
    logic        avm_chipselect, avm_write, avm_clken;
    logic [3:0]  avm_byteenable;
    logic [31:0] avm_readdata;
    logic [31:0] st_data;
    logic        st_valid, st_ready, st_last;

    fb_scan_master dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .start          (start),
        .base_addr      (base_addr),
        .length         (length),
        .busy           (busy),
        .done           (done),
        .avm_address    (avm_address),
        .avm_chipselect (avm_chipselect),
        .avm_write      (avm_write),
        .avm_byteenable (avm_byteenable),
        .avm_clken      (avm_clken),
        .avm_readdata   (avm_readdata),
        .st_data        (st_data),
        .st_valid       (st_valid),
        .st_ready       (st_ready),
        .st_last        (st_last)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [9:0]  base;
        logic [10:0] len;
        logic [3:0]  pat;
        logic [9:0]  first;
        logic [9:0]  last;
    } vec_t;

    logic [31:0] mem [1024];
    logic [9:0]  exp_addr [$];
    logic [32:0] exp_word [$];
    logic [9:0]  ea;
    logic [32:0] ew;
    logic [31:0] held_data;
    logic        held_last;
    logic [9:0]  first_addr, last_addr;
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          cs_cnt = 0, hs_cnt = 0, done_cnt = 0;
    int          done_cyc = 0, hs_cyc = 0, first_cs_cyc = 0, last_cs_cyc = 0;
    bit          prev_stall = 0, prev_done = 0, xfer_open = 0;

    // Single-port memory with one cycle of read latency.
    always @(posedge clk) begin
        if (avm_chipselect) avm_readdata <= mem[avm_address];
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input bit ok, input string name, input logic [63:0] act,
                         input logic [63:0] req);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    always @(negedge clk) begin
        check(avm_write == 1'b0 && avm_byteenable == 4'hF && avm_clken == 1'b1, "const_outputs",
              {avm_write, avm_byteenable, avm_clken}, 6'b0_1111_1);
        if (!reset_n) begin
            cs_cnt     = 0;
            hs_cnt     = 0;
            prev_stall = 0;
            prev_done  = 0;
            xfer_open  = 0;
        end else begin
            if (prev_stall) begin
                check(st_valid && st_data == held_data && st_last == held_last, "stall_stable",
                      {st_valid, st_last, st_data}, {1'b1, held_last, held_data});
            end
            if (avm_chipselect) begin
                cs_cnt++;
                if (!xfer_open) begin
                    first_addr   = avm_address;
                    first_cs_cyc = cyc;
                    xfer_open    = 1;
                end
                last_addr   = avm_address;
                last_cs_cyc = cyc;
                check(busy, "busy_while_reading", busy, 1);
                if (exp_addr.size() == 0) begin
                    check(0, "unexpected_read", avm_address, 0);
                end else begin
                    ea = exp_addr.pop_front();
                    check(avm_address == ea, "read_addr", avm_address, ea);
                end
            end
            if (st_valid && st_ready) begin
                hs_cnt++;
                hs_cyc = cyc;
                if (exp_word.size() == 0) begin
                    check(0, "unexpected_word", {st_last, st_data}, 0);
                end else begin
                    ew = exp_word.pop_front();
                    check({st_last, st_data} == ew, "stream_word", {st_last, st_data}, ew);
                end
            end
            check(cs_cnt - hs_cnt <= 4, "outstanding", cs_cnt - hs_cnt, 4);
            if (done) begin
                done_cnt++;
                done_cyc  = cyc;
                xfer_open = 0;
                check(!busy, "busy_low_at_done", busy, 0);
                check(!prev_done, "done_one_cycle", prev_done, 0);
            end
            prev_done  = done;
            prev_stall = st_valid && !st_ready;
            held_data  = st_data;
            held_last  = st_last;
        end
    end

    task automatic push_exp(input logic [9:0] b, input logic [10:0] n);
        for (int k = 0; k < int'(n); k++) begin
            logic [9:0] a;
            a = b + 10'(k);
            exp_addr.push_back(a);
            exp_word.push_back({k == int'(n) - 1, mem[a]});
        end
    endtask

    task automatic pulse_start(input logic [9:0] b, input logic [10:0] n);
        @(posedge clk); #1;
        start = 1; base_addr = b; length = n;
        @(posedge clk); #1;
        start = 0;
    endtask

    task automatic wait_done(input int d0, input int budget);
        int t;
        t = 0;
        while (done_cnt == d0 && t < budget) begin
            @(posedge clk); #1;
            t++;
        end
        check(done_cnt == d0 + 1, "done_seen", done_cnt - d0, 1);
    endtask

    task automatic check_idle(input string name);
        check({busy, done, avm_chipselect, st_valid, st_last} == 5'b0, name,
              {busy, done, avm_chipselect, st_valid, st_last}, 0);
        check(avm_address == 10'd0 && st_data == 32'd0, name, {avm_address, st_data}, 0);
    endtask

    task automatic run_xfer(input vec_t v);
        int c0, d0, sc, t;
        c0 = cs_cnt;
        d0 = done_cnt;
        push_exp(v.base, v.len);
        @(posedge clk); #1;
        start = 1; base_addr = v.base; length = v.len; st_ready = v.pat[0];
        sc = cyc;
        @(posedge clk); #1;
        start = 0;
        check(busy == (v.len != 0), "busy_after_start", busy, v.len != 0);
        t = 1;
        while (done_cnt == d0 && t < 4000) begin
            st_ready = v.pat[t % 4];
            @(posedge clk); #1;
            t++;
        end
        check(done_cnt == d0 + 1, "done_seen", done_cnt - d0, 1);
        check(cs_cnt - c0 == int'(v.len), "read_count", cs_cnt - c0, v.len);
        check(exp_word.size() == 0 && exp_addr.size() == 0, "scoreboard_drained",
              exp_word.size(), 0);
        if (v.len == 0) begin
            check(done_cyc == sc + 1, "done_zero_len", done_cyc - sc, 1);
        end else begin
            check(done_cyc == hs_cyc + 1, "done_after_last", done_cyc - hs_cyc, 1);
            check(first_addr == v.first, "first_addr", first_addr, v.first);
            check(last_addr == v.last, "last_addr", last_addr, v.last);
            if (v.pat == 4'hF) begin
                check(last_cs_cyc - first_cs_cyc == int'(v.len) - 1, "back_to_back",
                      last_cs_cyc - first_cs_cyc, v.len - 1);
            end
        end
    endtask

    vec_t vecs [7];
    int   c0, d0, h0, t;

    initial begin
        vecs[0] = '{base: 10'd16,   len: 11'd8,    pat: 4'b1111, first: 10'd16,   last: 10'd23};
        vecs[1] = '{base: 10'd0,    len: 11'd12,   pat: 4'b1001, first: 10'd0,    last: 10'd11};
        vecs[2] = '{base: 10'd1022, len: 11'd4,    pat: 4'b1111, first: 10'd1022, last: 10'd1};
        vecs[3] = '{base: 10'd5,    len: 11'd1024, pat: 4'b1111, first: 10'd5,    last: 10'd4};
        vecs[4] = '{base: 10'd9,    len: 11'd0,    pat: 4'b1111, first: 10'd0,    last: 10'd0};
        vecs[5] = '{base: 10'd777,  len: 11'd7,    pat: 4'b0101, first: 10'd777,  last: 10'd783};
        vecs[6] = '{base: 10'd1020, len: 11'd9,    pat: 4'b0011, first: 10'd1020, last: 10'd4};

        for (int i = 0; i < 1024; i++) mem[i] = 32'hA000_0000 + i;
        reset_n = 0; start = 0; base_addr = '0; length = '0; st_ready = 0;
        repeat (2) @(posedge clk);
        #1;
        check_idle("reset_values");
        reset_n = 1;

        for (int i = 0; i < 7; i++) run_xfer(vecs[i]);

        // Start pulse during a transfer must be ignored.
        st_ready = 1;
        c0 = cs_cnt;
        d0 = done_cnt;
        push_exp(10'd200, 11'd6);
        pulse_start(10'd200, 11'd6);
        @(posedge clk); #1;
        pulse_start(10'd0, 11'd3);
        wait_done(d0, 100);
        check(cs_cnt - c0 == 6, "ignored_start_count", cs_cnt - c0, 6);
        repeat (4) @(posedge clk);
        #1;
        check(!busy && done_cnt == d0 + 1 && exp_word.size() == 0, "ignored_start_quiet",
              {busy, done_cnt[7:0]}, d0 + 1);

        // Asynchronous reset after three words of a ten-word transfer.
        h0 = hs_cnt;
        d0 = done_cnt;
        push_exp(10'd300, 11'd10);
        pulse_start(10'd300, 11'd10);
        t = 0;
        while (hs_cnt < h0 + 3 && t < 50) begin
            @(posedge clk); #1;
            t++;
        end
        check(hs_cnt >= h0 + 3, "reset_progress", hs_cnt - h0, 3);
        reset_n = 0;
        #1;
        check_idle("reset_mid_xfer");
        exp_addr.delete();
        exp_word.delete();
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            check_idle("reset_held");
        end
        reset_n = 1;
        check(done_cnt == d0, "no_done_on_reset", done_cnt - d0, 0);
        run_xfer('{base: 10'd400, len: 11'd5, pat: 4'b1111, first: 10'd400, last: 10'd404});

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fb_scan_master.md
Name: fb_scan_master

Overview:
- Avalon-MM read initiator that sweeps a contiguous word range of the 1024x32 single-port on-chip frame memory.
- Returns the words as a valid/ready pixel stream toward the display path.
- Sits between the control registers (start/base/length) and the memory's s1 slave port.
- Never writes the memory.

Parameters:
ADDR_W, 10, memory word-address width; addresses wrap modulo 2^ADDR_W
DATA_W, 32, memory and stream data width
LEN_W, 11, transfer-length width; maximum length is 2^ADDR_W words
RD_LATENCY, 1, fixed cycles from address issue to readdata valid
FIFO_DEPTH, 4, output buffer entries; power of two, at least RD_LATENCY+1

Ports:
clk  in  1  single clock for all logic
reset_n  in  1  asynchronous active-low reset
start  in  1  one-cycle request; sampled only in IDLE
base_addr  in  ADDR_W  first word address, captured on accepted start
length  in  LEN_W  word count, captured on accepted start
busy  out  1  high from accepted start until done
done  out  1  one-cycle pulse when the last word has left the stream
avm_address  out  ADDR_W  memory word address
avm_chipselect  out  1  high on a cycle that issues a read
avm_write  out  1  constant 0
avm_byteenable  out  DATA_W/8  constant all-ones
avm_clken  out  1  constant 1
avm_readdata  in  DATA_W  memory read data, valid RD_LATENCY cycles after issue
st_data  out  DATA_W  stream word (FIFO head)
st_valid  out  1  FIFO not empty
st_ready  in  1  sink accepts the word when st_valid && st_ready
st_last  out  1  marks the final word of the transfer

Behaviour:
- Reset values: busy=0, done=0, avm_address=0, avm_chipselect=0, st_valid=0, st_last=0, st_data=0, FIFO empty, all counters 0, state IDLE.
- States: IDLE, ISSUE, DRAIN, FIN.
- IDLE:
  - start && length!=0: capture base_addr into addr_q and length into remain_q; go to ISSUE; busy=1 next cycle.
  - start && length==0: go to FIN; no memory access.
  - start while not IDLE is ignored.
- ISSUE:
  - credit = FIFO_DEPTH - fifo_count - inflight.
  - Issue a read when remain_q!=0 && credit>0: chipselect=1 and address=addr_q in that cycle; addr_q increments with wrap at 2^ADDR_W; remain_q decrements.
  - The read reserves credit immediately (counts as inflight).
  - After the last issue, go to DRAIN.
- Return path:
  - A RD_LATENCY-deep valid shift register tags issued cycles.
  - On tag exit, avm_readdata is pushed into the FIFO, together with a last flag set when that read was the final issue.
  - The FIFO can never overflow; an overflow is an assertion failure.
- DRAIN: stays until inflight==0 && FIFO empty && the last word has been accepted; then go to FIN.
- FIN: done=1 for exactly one cycle; busy=0; go to IDLE. From FIN, busy falls and done rises together.
- Stream rules:
  - st_data, st_valid and st_last are stable while st_valid && !st_ready.
  - FIFO push and pop in the same cycle are allowed; the count is unchanged.
  - st_ready may toggle arbitrarily.
- Throughput: with st_ready held high, one word is accepted per cycle after the initial RD_LATENCY+1 cycles.
- Wrap: base_addr=1022, length=4 reads 1022, 1023, 0, 1.
- length = 2^ADDR_W (1024) is legal and reads every word once.
- Asynchronous reset mid-transfer: everything returns to reset values immediately; in-flight data is discarded; no done pulse.

Decomposition:
- Shared package fb_pkg holds:
  - constants FB_ADDR_W=10, FB_DATA_W=32, FB_RD_LATENCY=1;
  - the state enum typedef (IDLE/ISSUE/DRAIN/FIN).
- One sub-module: fb_scan_fifo.
  - Synchronous FIFO of width DATA_W+1 (data plus last flag), depth FIFO_DEPTH.
  - Outputs count, empty and full.
  - Same clk/reset_n.

Test Plan:
- Basic transfer: memory preloaded with word i = 0xA000_0000+i; start, base=16, length=8, st_ready=1 -> addresses 16..23 issued on consecutive cycles; stream 0xA000_0010..0xA000_0017; st_last on the 8th word; done one cycle after the last handshake.
- Backpressure: base=0, length=12, st_ready pattern 1,0,0,1 repeating -> at most 4 reads outstanding+buffered; no word lost or duplicated; data held stable while stalled.
- Wrap and full range: base=1022, length=4 -> addresses 1022, 1023, 0, 1. Then base=5, length=1024 -> exactly 1024 reads; word 1023 is followed by word 0; st_last on the word at address 4.
- Zero length and ignored start: start with length=0 -> done one cycle later, chipselect never high. A second start pulse during a busy transfer -> no effect on the transfer or its count.
- Reset mid-operation: assert reset_n=0 after 3 words of a length=10 transfer -> all outputs 0 within the reset; no done. A fresh start after release transfers correctly from the new base.
- Constant outputs: over all tests, avm_write=0, avm_byteenable=4'hF and avm_clken=1 every cycle.
